spi_reg_burst: RTL and testbench

SPI_REG_BURST -- requirements
Module: spi_reg_burst

---
 rtl/spi_reg_burst_if.sv | 33 +++
 rtl/spi_reg_burst.sv | 215 +++++++++++++++++++++
 tb/tb_spi_reg_burst.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_burst_if.sv
// SPI pins plus register-side bus of spi_reg_burst, grouped for port connection.
// slave: the spi_reg_burst block; master: the SPI host and register file driving it.
interface spi_reg_burst_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned REG_W  = 16
);
    logic [1:0]        mode;
    logic              sclk;
    logic              mosi;
    logic              nss;
    logic              miso;
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_data_i;
    logic [REG_W-1:0]  reg_data_o;
    logic              reg_data_o_vld;
    logic              reg_rd_stb;
    logic [7:0]        status;
    logic [5:0]        fastcmd;
    logic              fastcmd_vld;
    logic              frame_err;

    modport master (
        output mode, sclk, mosi, nss, reg_data_i, status,
        input  miso, reg_addr, reg_data_o, reg_data_o_vld, reg_rd_stb,
               fastcmd, fastcmd_vld, frame_err
    );

    modport slave (
        input  mode, sclk, mosi, nss, reg_data_i, status,
        output miso, reg_addr, reg_data_o, reg_data_o_vld, reg_rd_stb,
               fastcmd, fastcmd_vld, frame_err
    );
endinterface

// File: rtl/spi_reg_burst.sv
// SPI slave giving burst read/write access to a register file, with a command byte,
// auto-incrementing address, fast commands and mid-word abort detection.
module spi_reg_burst #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned REG_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           nrst,
    spi_reg_burst_if.slave bus
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned SYN_W = SYNC_STAGES + 1;

    typedef enum logic [2:0] {
        WAIT_DESEL,
        IDLE,
        CMD,
        DATA,
        DRAIN
    } state_e;

    logic [SYN_W-1:0]  sclk_sr_q;
    logic [SYN_W-1:0]  mosi_sr_q;
    logic [SYN_W-1:0]  nss_sr_q;

    state_e            state_q;
    logic [1:0]        mode_q;
    logic              first_q;
    logic              reload_q;
    logic              wr_q;
    logic              inc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [REG_W-1:0]  osr_q;
    logic [REG_W-1:0]  isr_q;
    logic [REG_W-1:0]  reg_data_o_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [5:0]        fastcmd_q;
    logic              miso_q;
    logic              vld_q;
    logic              rd_stb_q;
    logic              fast_vld_q;
    logic              frame_err_q;

    logic              sclk_s;
    logic              sclk_h;
    logic              nss_s;
    logic              nss_fall;
    logic              bit_in;
    logic              lead;
    logic              trail;
    logic              sample_ev;
    logic              shift_ev;
    logic              word_done;
    logic [REG_W-1:0]  word_in;
    logic [7:0]        cmd;

    // Pin synchronisers; the extra top flop is the history used for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_sr_q <= '0;
            mosi_sr_q <= '0;
            nss_sr_q  <= '0;
        end else begin
            sclk_sr_q <= {sclk_sr_q[SYN_W-2:0], bus.sclk};
            mosi_sr_q <= {mosi_sr_q[SYN_W-2:0], bus.mosi};
            nss_sr_q  <= {nss_sr_q[SYN_W-2:0], bus.nss};
        end
    end

    // Edge classification from the frame's captured {CPOL,CPHA}.
    always_comb begin
        sclk_s    = sclk_sr_q[SYNC_STAGES-1];
        sclk_h    = sclk_sr_q[SYNC_STAGES];
        nss_s     = nss_sr_q[SYNC_STAGES-1];
        nss_fall  = ~nss_sr_q[SYNC_STAGES-1] & nss_sr_q[SYNC_STAGES];
        bit_in    = mosi_sr_q[SYNC_STAGES];
        lead      = mode_q[1] ? (~sclk_s & sclk_h) : (sclk_s & ~sclk_h);
        trail     = mode_q[1] ? (sclk_s & ~sclk_h) : (~sclk_s & sclk_h);
        sample_ev = mode_q[0] ? trail : lead;
        shift_ev  = mode_q[0] ? (lead & ~first_q) : trail;
        word_in   = {isr_q[REG_W-2:0], bit_in};
        cmd       = word_in[7:0];
        word_done = ((state_q == CMD)  && (cnt_q == CNT_W'(7))) ||
                    ((state_q == DATA) && (cnt_q == CNT_W'(REG_W - 1)));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= WAIT_DESEL;
            mode_q       <= '0;
            first_q      <= 1'b0;
            reload_q     <= 1'b0;
            wr_q         <= 1'b0;
            inc_q        <= 1'b0;
            cnt_q        <= '0;
            osr_q        <= '0;
            isr_q        <= '0;
            reg_data_o_q <= '0;
            reg_addr_q   <= '0;
            fastcmd_q    <= '0;
            miso_q       <= 1'b0;
            vld_q        <= 1'b0;
            rd_stb_q     <= 1'b0;
            fast_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vld_q       <= 1'b0;
            rd_stb_q    <= 1'b0;
            fast_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            inc_q       <= 1'b0;
            // Address advances one clk after the strobe that used it.
            if (inc_q) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end
            case (state_q)
                WAIT_DESEL: begin
                    if (nss_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (nss_fall) begin
                        state_q  <= CMD;
                        mode_q   <= bus.mode;
                        first_q  <= 1'b1;
                        reload_q <= 1'b0;
                        cnt_q    <= '0;
                        osr_q    <= REG_W'(bus.status) << (REG_W - 8);
                        miso_q   <= bus.status[7];
                    end
                end
                CMD, DATA: begin
                    // Deselect has priority over any edge seen in the same clk.
                    if (nss_s) begin
                        state_q     <= IDLE;
                        frame_err_q <= (cnt_q != '0);
                        reload_q    <= 1'b0;
                        miso_q      <= 1'b0;
                    end else begin
                        if (lead) begin
                            first_q <= 1'b0;
                        end
                        if (shift_ev) begin
                            if (reload_q) begin
                                osr_q    <= bus.reg_data_i;
                                miso_q   <= bus.reg_data_i[REG_W-1];
                                rd_stb_q <= 1'b1;
                                inc_q    <= 1'b1;
                                reload_q <= 1'b0;
                            end else begin
                                osr_q  <= osr_q << 1;
                                miso_q <= osr_q[REG_W-2];
                            end
                        end
                        if (sample_ev) begin
                            isr_q <= word_in;
                            cnt_q <= word_done ? '0 : cnt_q + CNT_W'(1);
                            if (word_done && (state_q == CMD)) begin
                                reg_addr_q <= cmd[ADDR_W-1:0];
                                case (cmd[7:6])
                                    2'b00: begin
                                        state_q  <= DATA;
                                        wr_q     <= 1'b0;
                                        reload_q <= 1'b1;
                                    end
                                    2'b10: begin
                                        state_q <= DATA;
                                        wr_q    <= 1'b1;
                                    end
                                    2'b11: begin
                                        state_q    <= DRAIN;
                                        fastcmd_q  <= cmd[5:0];
                                        fast_vld_q <= 1'b1;
                                        miso_q     <= 1'b0;
                                    end
                                    default: begin
                                        state_q <= DRAIN;
                                        miso_q  <= 1'b0;
                                    end
                                endcase
                            end else if (word_done) begin
                                if (wr_q) begin
                                    reg_data_o_q <= word_in;
                                    vld_q        <= 1'b1;
                                    inc_q        <= 1'b1;
                                end else begin
                                    reload_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (nss_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= WAIT_DESEL;
                end
            endcase
        end
    end

    assign bus.miso           = miso_q;
    assign bus.reg_addr       = reg_addr_q;
    assign bus.reg_data_o     = reg_data_o_q;
    assign bus.reg_data_o_vld = vld_q;
    assign bus.reg_rd_stb     = rd_stb_q;
    assign bus.fastcmd        = fastcmd_q;
    assign bus.fastcmd_vld    = fast_vld_q;
    assign bus.frame_err      = frame_err_q;
endmodule

// File: tb/tb_spi_reg_burst.sv
// Bench for spi_reg_burst: a bit-level SPI master drives frames, a frame-level model
// queues the expected strobes and miso words, and a monitor compares as they appear.
module tb_spi_reg_burst;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned REG_W  = 16;
    localparam int unsigned HALF   = 6;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [REG_W-1:0] mem    [64];
    logic [REG_W-1:0] wwords [8];
    logic             tx     [256];
    logic             rx     [256];

    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_rd_addr[$];
    int exp_fast[$];
    int exp_err[$];
    int exp_miso[$];
    int got_miso[$];

    spi_reg_burst_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    spi_reg_burst #(.ADDR_W(ADDR_W), .REG_W(REG_W), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Host register file: read data is a combinational lookup of the current address.
    always_comb bus.reg_data_i = mem[bus.reg_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: strobe seen while none expected", name);
    endtask

    // Monitor: every strobe pops the matching expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.reg_data_o_vld !== 1'b0) begin
                if (exp_wr_addr.size() == 0) unexpected("wr_vld");
                else begin
                    check("wr_addr", 32'(bus.reg_addr), exp_wr_addr.pop_front());
                    check("wr_data", 32'(bus.reg_data_o), exp_wr_data.pop_front());
                end
            end
            if (bus.reg_rd_stb !== 1'b0) begin
                if (exp_rd_addr.size() == 0) unexpected("rd_stb");
                else check("rd_addr", 32'(bus.reg_addr), exp_rd_addr.pop_front());
            end
            if (bus.fastcmd_vld !== 1'b0) begin
                if (exp_fast.size() == 0) unexpected("fastcmd_vld");
                else check("fastcmd", 32'(bus.fastcmd), exp_fast.pop_front());
            end
            if (bus.frame_err !== 1'b0) begin
                if (exp_err.size() == 0) unexpected("frame_err");
                else check("frame_err", 32'(bus.frame_err), exp_err.pop_front());
            end
            while (got_miso.size() > 0 && exp_miso.size() > 0)
                check("miso_word", got_miso.pop_front(), exp_miso.pop_front());
        end
    end

    task automatic reset_check();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso",        32'(bus.miso), 0);
        check("rst_reg_addr",    32'(bus.reg_addr), 0);
        check("rst_reg_data_o",  32'(bus.reg_data_o), 0);
        check("rst_vld",         32'(bus.reg_data_o_vld), 0);
        check("rst_rd_stb",      32'(bus.reg_rd_stb), 0);
        check("rst_fastcmd",     32'(bus.fastcmd), 0);
        check("rst_fastcmd_vld", 32'(bus.fastcmd_vld), 0);
        check("rst_frame_err",   32'(bus.frame_err), 0);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // Bit-level SPI master; rst_at >= 0 pulses nrst before that bit index.
    task automatic spi_xfer(input logic [1:0] m, input int nbits, input int rst_at);
        bus.mode = m;
        bus.sclk = m[1];
        repeat (HALF) @(negedge clk);
        bus.nss  = 1'b0;
        bus.mosi = m[0] ? 1'b0 : tx[0];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) reset_check();
            bus.sclk = ~m[1];
            if (m[0]) bus.mosi = tx[i];
            else      rx[i] = bus.miso;
            repeat (HALF) @(negedge clk);
            bus.sclk = m[1];
            if (m[0])               rx[i] = bus.miso;
            else if (i + 1 < nbits) bus.mosi = tx[i+1];
            repeat (HALF) @(negedge clk);
        end
        bus.nss = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // One frame: command byte, nwords full words (write data from wwords), extra partial bits.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] cmd, input int nwords,
                             input int extra, input logic [7:0] st, input int rst_at);
        int nbits, a, op, strobes, a_end, base;
        logic [31:0] v;
        nbits = 8 + nwords * REG_W + extra;
        for (int b = 0; b < 8; b++) tx[b] = cmd[7-b];
        for (int k = 0; k < nwords; k++)
            for (int b = 0; b < REG_W; b++) tx[8 + k*REG_W + b] = wwords[k][REG_W-1-b];
        for (int b = 0; b < extra; b++) tx[8 + nwords*REG_W + b] = 1'($urandom_range(0, 1));
        bus.status = st;
        a     = int'(cmd[5:0]);
        op    = int'(cmd[7:6]);
        a_end = a;
        if (rst_at < 0) begin
            exp_miso.push_back(int'(st));
            case (op)
                0: begin
                    // CPHA=1 reloads only on a leading edge that follows the word.
                    strobes = m[0] ? nwords + ((extra > 0) ? 1 : 0) : nwords + 1;
                    for (int j = 0; j < strobes; j++) exp_rd_addr.push_back((a + j) % 64);
                    for (int k = 0; k < nwords; k++) exp_miso.push_back(int'(mem[(a + k) % 64]));
                    a_end = (a + strobes) % 64;
                    if (extra > 0) exp_err.push_back(1);
                end
                2: begin
                    for (int k = 0; k < nwords; k++) begin
                        exp_wr_addr.push_back((a + k) % 64);
                        exp_wr_data.push_back(int'(wwords[k]));
                        exp_miso.push_back(0);
                    end
                    a_end = (a + nwords) % 64;
                    if (extra > 0) exp_err.push_back(1);
                end
                3: exp_fast.push_back(int'(cmd[5:0]));
                default: for (int k = 0; k < nwords; k++) exp_miso.push_back(0);
            endcase
        end
        spi_xfer(m, nbits, rst_at);
        if (rst_at < 0) begin
            v = '0;
            for (int b = 0; b < 8; b++) v = {v[30:0], rx[b]};
            got_miso.push_back(int'(v));
            if (op != 3) begin
                for (int k = 0; k < nwords; k++) begin
                    v = '0;
                    base = 8 + k * REG_W;
                    for (int b = 0; b < REG_W; b++) v = {v[30:0], rx[base + b]};
                    got_miso.push_back(int'(v));
                end
            end
            repeat (4) @(negedge clk);
            check("reg_addr_end", 32'(bus.reg_addr), 32'(a_end));
        end else begin
            check("reg_addr_after_abort", 32'(bus.reg_addr), 0);
        end
    endtask

    initial begin
        int nw, ex;
        logic [7:0] c;
        logic [1:0] ops [4];
        ops[0] = 2'b00; ops[1] = 2'b10; ops[2] = 2'b11; ops[3] = 2'b01;
        for (int a = 0; a < 64; a++) mem[a] = {8'(a), 8'hA0 + 8'(a)};
        bus.mode = 2'b00; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.nss = 1'b1; bus.status = 8'h00;
        reset_check();
        repeat (8) @(negedge clk);

        // Mode 0 two-word write at address 2
        wwords[0] = 16'hBEEF; wwords[1] = 16'h1234;
        run_frame(2'b00, 8'h82, 2, 0, 8'h00, -1);
        // Mode 3 read from address 5 with status byte
        run_frame(2'b11, 8'h05, 2, 0, 8'h5A, -1);
        // Mode 1 fast command followed by 16 ignored clocks
        wwords[0] = 16'hFFFF;
        run_frame(2'b01, 8'hEA, 1, 0, 8'h33, -1);
        // Mode 2 write wrapping from 0x3F to 0
        wwords[0] = 16'hA5A5; wwords[1] = 16'h5A5A;
        run_frame(2'b10, 8'hBF, 2, 0, 8'hC3, -1);
        // Aborted write (5 data bits), then a clean one
        run_frame(2'b00, 8'h81, 0, 5, 8'h11, -1);
        wwords[0] = 16'h00FF;
        run_frame(2'b00, 8'h81, 1, 0, 8'h22, -1);
        // Reset after 4 bits of a read frame; frame must not decode
        run_frame(2'b00, 8'h07, 1, 0, 8'h44, 4);
        run_frame(2'b00, 8'h07, 1, 0, 8'h99, -1);

        // Randomized frames
        for (int a = 0; a < 64; a++) mem[a] = REG_W'($urandom);
        for (int f = 0; f < 36; f++) begin
            c  = {ops[$urandom_range(0, 3)], 6'($urandom)};
            nw = $urandom_range(0, 3);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, REG_W - 1) : 0;
            for (int k = 0; k < 8; k++) wwords[k] = REG_W'($urandom);
            run_frame(2'($urandom_range(0, 3)), c, nw, ex, 8'($urandom), -1);
        end

        repeat (10) @(negedge clk);
        check("left_wr",   32'(exp_wr_addr.size()), 0);
        check("left_rd",   32'(exp_rd_addr.size()), 0);
        check("left_fast", 32'(exp_fast.size()), 0);
        check("left_err",  32'(exp_err.size()), 0);
        check("left_miso", 32'(exp_miso.size()), 0);
        check("left_got",  32'(got_miso.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
